// File: rtl/countdown_pkg.sv
// Shared types and helpers for the two-digit countdown sequencer.
package countdown_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam int unsigned BCD_MAX = 9;

  // Decrement a {tens, ones} pair; ones borrows from tens at zero.
  function automatic logic [6:0] bcd_dec2(input logic [2:0] tens, input logic [3:0] ones);
    logic [6:0] res;
    if (ones == 4'd0) begin
      res = {tens - 3'd1, 4'(BCD_MAX)};
    end else begin
      res = {tens, ones - 4'd1};
    end
    return res;
  endfunction

endpackage

// File: rtl/btn_onepulse.sv
// Button synchronizer and rising-edge detector: one press pulse per button push.
module btn_onepulse (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic press
);

  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign press = s2 & ~s3;

endmodule

// File: rtl/countdown_seq.sv
// Button-driven two-digit countdown: idle/run/pause/done FSM gating a prescaled
// tick into a BCD down-counter.
module countdown_seq
  import countdown_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 100_000_000,
  parameter int unsigned INIT_TENS = 3,
  parameter int unsigned INIT_ONES = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in,
  output logic [2:0] a,
  output logic [3:0] b,
  output logic       stateled,
  output logic       endled
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TickLast = PW'(TICK_DIV - 1);
  localparam logic [2:0] InitTens = 3'(INIT_TENS);
  localparam logic [3:0] InitOnes = 4'(INIT_ONES);
  localparam logic InitZero = (INIT_TENS == 0) && (INIT_ONES == 0);

  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic [2:0]    tens_q;
  logic [3:0]    ones_q;
  logic          press;
  logic          tick;
  logic          at_one;
  logic [6:0]    dec;

  btn_onepulse u_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in),
    .press (press)
  );

  assign tick   = (presc_q == TickLast);
  assign at_one = (tens_q == 3'd0) && (ones_q == 4'd1);
  assign dec    = bcd_dec2(tens_q, ones_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      presc_q  <= '0;
      tens_q   <= InitTens;
      ones_q   <= InitOnes;
      stateled <= 1'b0;
      endled   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          presc_q <= '0;
          tens_q  <= InitTens;
          ones_q  <= InitOnes;
          if (press) begin
            if (InitZero) begin
              state_q <= StDone;
              endled  <= 1'b1;
            end else begin
              state_q  <= StRun;
              stateled <= 1'b1;
            end
          end
        end
        StRun: begin
          presc_q <= tick ? '0 : presc_q + PW'(1);
          if (tick) begin
            {tens_q, ones_q} <= dec;
          end
          // Expiry wins over a coincident press; the press is dropped.
          if (tick && at_one) begin
            state_q  <= StDone;
            presc_q  <= '0;
            stateled <= 1'b0;
            endled   <= 1'b1;
          end else if (press) begin
            state_q  <= StPause;
            stateled <= 1'b0;
          end
        end
        StPause: begin
          if (press) begin
            state_q  <= StRun;
            stateled <= 1'b1;
          end
        end
        StDone: begin
          presc_q <= '0;
          tens_q  <= 3'd0;
          ones_q  <= 4'd0;
          if (press) begin
            state_q <= StIdle;
            endled  <= 1'b0;
            tens_q  <= InitTens;
            ones_q  <= InitOnes;
          end
        end
        default: begin
          state_q  <= StIdle;
          stateled <= 1'b0;
          endled   <= 1'b0;
        end
      endcase
    end
  end

  assign a = tens_q;
  assign b = ones_q;

endmodule

// File: tb/tb_countdown_seq.sv
// Directed bench for countdown_seq: three instances (INIT 3/0, 1/2, 0/0), TICK_DIV = 4.
module tb_countdown_seq;

  logic clk;
  logic rst_n;
  logic btn;
  int   sel;
  logic in0, in1, in2;
  logic [2:0] a0, a1, a2;
  logic [3:0] b0, b1, b2;
  logic sl0, sl1, sl2, el0, el1, el2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       btn;
    int         cycles;
    logic [2:0] a;
    logic [3:0] b;
    logic       sl;
    logic       el;
  } vec_t;

  vec_t vq[$];

  assign in0 = btn && (sel == 0);
  assign in1 = btn && (sel == 1);
  assign in2 = btn && (sel == 2);

  countdown_seq #(.TICK_DIV(4), .INIT_TENS(3), .INIT_ONES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in(in0), .a(a0), .b(b0), .stateled(sl0), .endled(el0)
  );
  countdown_seq #(.TICK_DIV(4), .INIT_TENS(1), .INIT_ONES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in(in1), .a(a1), .b(b1), .stateled(sl1), .endled(el1)
  );
  countdown_seq #(.TICK_DIV(4), .INIT_TENS(0), .INIT_ONES(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in(in2), .a(a2), .b(b2), .stateled(sl2), .endled(el2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int s, input logic [2:0] ea, input logic [3:0] eb,
                     input logic es, input logic ee);
    logic [2:0] ga;
    logic [3:0] gb;
    logic gs, ge;
    case (s)
      0:       begin ga = a0; gb = b0; gs = sl0; ge = el0; end
      1:       begin ga = a1; gb = b1; gs = sl1; ge = el1; end
      default: begin ga = a2; gb = b2; gs = sl2; ge = el2; end
    endcase
    checks++;
    if ({ga, gb, gs, ge} !== {ea, eb, es, ee}) begin
      errors++;
      $display("FAIL %s dut%0d: got a=%0d b=%0d stateled=%b endled=%b, want a=%0d b=%0d stateled=%b endled=%b",
               nm, s, ga, gb, gs, ge, ea, eb, es, ee);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press lands on the state register at the third rising edge.
  task automatic press();
    btn = 1'b1;
    run(3);
    btn = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish before 100000");
    $fatal(1);
  end

  initial begin
    btn   = 1'b0;
    sel   = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_async", 0, 3'd3, 4'd0, 1'b0, 1'b0);
    chk("reset_async", 1, 3'd1, 4'd2, 1'b0, 1'b0);
    chk("reset_async", 2, 3'd0, 4'd0, 1'b0, 1'b0);
    run(2);
    rst_n = 1'b1;
    run(2);

    // INIT 00 goes straight to DONE.
    sel = 2;
    chk("zero_idle", 2, 3'd0, 4'd0, 1'b0, 1'b0);
    press();
    chk("zero_done", 2, 3'd0, 4'd0, 1'b0, 1'b1);
    run(2);

    // Full count from 12 on dut1, driven from a vector table.
    sel = 1;
    vq.push_back('{1'b1, 3, 3'd1, 4'd2, 1'b1, 1'b0});
    vq.push_back('{1'b0, 3, 3'd1, 4'd2, 1'b1, 1'b0});
    vq.push_back('{1'b0, 1, 3'd1, 4'd1, 1'b1, 1'b0});
    for (int v = 10; v >= 1; v--) begin
      vq.push_back('{1'b0, 4, 3'(v / 10), 4'(v % 10), 1'b1, 1'b0});
    end
    vq.push_back('{1'b0, 4, 3'd0, 4'd0, 1'b0, 1'b1});
    vq.push_back('{1'b0, 4, 3'd0, 4'd0, 1'b0, 1'b1});
    vq.push_back('{1'b1, 3, 3'd1, 4'd2, 1'b0, 1'b0});
    vq.push_back('{1'b0, 2, 3'd1, 4'd2, 1'b0, 1'b0});
    for (int i = 0; i < vq.size(); i++) begin
      btn = vq[i].btn;
      run(vq[i].cycles);
      chk($sformatf("count_vec%0d", i), 1, vq[i].a, vq[i].b, vq[i].sl, vq[i].el);
    end
    btn = 1'b0;
    run(2);

    // Pause/resume and corner cases on dut0 (INIT 30).
    sel = 0;
    press();
    chk("run_start", 0, 3'd3, 4'd0, 1'b1, 1'b0);
    run(8);
    chk("two_ticks", 0, 3'd2, 4'd8, 1'b1, 1'b0);
    press();
    chk("pause", 0, 3'd2, 4'd8, 1'b0, 1'b0);
    run(40);
    chk("pause_hold", 0, 3'd2, 4'd8, 1'b0, 1'b0);
    press();
    chk("resume", 0, 3'd2, 4'd8, 1'b1, 1'b0);
    run(1);
    chk("resume_phase", 0, 3'd2, 4'd7, 1'b1, 1'b0);
    run(24);
    chk("at21", 0, 3'd2, 4'd1, 1'b1, 1'b0);
    run(1);
    press();
    chk("tick_press_21", 0, 3'd2, 4'd0, 1'b0, 1'b0);
    run(8);
    chk("paused_20", 0, 3'd2, 4'd0, 1'b0, 1'b0);
    press();
    chk("resume_20", 0, 3'd2, 4'd0, 1'b1, 1'b0);
    run(76);
    chk("at01", 0, 3'd0, 4'd1, 1'b1, 1'b0);
    run(1);
    press();
    chk("tick_press_01", 0, 3'd0, 4'd0, 1'b0, 1'b1);
    run(4);
    chk("done_hold", 0, 3'd0, 4'd0, 1'b0, 1'b1);
    press();
    chk("restart", 0, 3'd3, 4'd0, 1'b0, 1'b0);
    run(2);

    // Held button: one press only, so the count keeps running.
    btn = 1'b1;
    run(20);
    chk("held", 0, 3'd2, 4'd6, 1'b1, 1'b0);
    btn = 1'b0;
    run(3);
    chk("held_release", 0, 3'd2, 4'd5, 1'b1, 1'b0);
    run(32);
    chk("at17", 0, 3'd1, 4'd7, 1'b1, 1'b0);

    // Asynchronous reset mid-count, away from any clock edge.
    run(2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_run_reset", 0, 3'd3, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run(10);
    chk("no_spurious", 0, 3'd3, 4'd0, 1'b0, 1'b0);
    press();
    run(3);
    chk("post_reset_phase", 0, 3'd3, 4'd0, 1'b1, 1'b0);
    run(1);
    chk("post_reset_tick", 0, 3'd2, 4'd9, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
